// File: rtl/game_control_fsm_pkg.sv
// Shared definitions for the rhythm-game controller and the display decoder.
// Optional pause support is selected with the GAME_PAUSE_EN macro.
package game_control_fsm_pkg;

    // Screen-level game state; PAUSE is only reachable when pause is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } game_state_t;

    localparam int unsigned DEFAULT_MISS_LIMIT = 7;
    localparam int unsigned DEFAULT_COMBO_W    = 8;

endpackage

// File: rtl/game_control_fsm_if.sv
// Button / judge-pulse inputs and screen-select / counter outputs of the game
// controller. The controller uses the slave modport; the driver side uses master.
// The "interface" screen select is carried as interface_sel (keyword clash).
interface game_control_fsm_if
    import game_control_fsm_pkg::*;
#(
    parameter int unsigned MISS_W  = $clog2(DEFAULT_MISS_LIMIT + 1),
    parameter int unsigned COMBO_W = DEFAULT_COMBO_W
);
    logic               key_1;
    logic               key_2;
    logic               hit;
    logic               miss;
    logic               done;
    logic               interface_sel;
    logic               map;
    logic               paused;
    logic               win;
    logic               lose;
    logic [MISS_W-1:0]  total_miss;
    logic [COMBO_W-1:0] combo;
    logic [COMBO_W-1:0] max_combo;

    modport master (
        output key_1, key_2, hit, miss, done,
        input  interface_sel, map, paused, win, lose, total_miss, combo, max_combo
    );

    modport slave (
        input  key_1, key_2, hit, miss, done,
        output interface_sel, map, paused, win, lose, total_miss, combo, max_combo
    );
endinterface

// File: rtl/game_control_fsm_key_rise.sv
// Rising-edge detector for a debounced level key: one flop plus an AND gate.
// The flop's reset value is configurable; resetting it to 1 means a key held
// through reset produces no edge.
module game_control_fsm_key_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_rise
);
    logic r_key_q;

    // Remember last cycle's key level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_key_q <= RST_VAL;
        else        r_key_q <= i_key;
    end

    assign o_rise = i_key & ~r_key_q;
endmodule

// File: rtl/game_control_fsm.sv
// Rhythm-game top-level controller: title -> play -> win/lose sequencing,
// miss counting against MISS_LIMIT, current/best combo tracking.
// Optional macro GAME_PAUSE_EN: adds the PAUSE state (key_2 in PLAY pauses);
// without it key_2 in PLAY aborts to IDLE and paused is tied low.
module game_control_fsm
    import game_control_fsm_pkg::*;
#(
    parameter int unsigned MISS_LIMIT = DEFAULT_MISS_LIMIT,
    parameter int unsigned MISS_W     = $clog2(MISS_LIMIT + 1),
    parameter int unsigned COMBO_W    = DEFAULT_COMBO_W
) (
    input  logic                clk,
    input  logic                resetn,
    game_control_fsm_if.slave   bus
);
    game_state_t        r_state;
    game_state_t        w_next_state;
    logic [MISS_W-1:0]  r_total_miss;
    logic [COMBO_W-1:0] r_combo;
    logic [COMBO_W-1:0] r_max_combo;
    logic [COMBO_W-1:0] w_combo_inc;
    logic               w_k1_rise;
    logic               w_k2_rise;
    logic               w_last_miss;

    game_control_fsm_key_rise #(.RST_VAL(1'b1)) u_key1_rise (
        .clk    (clk),
        .rst_n  (resetn),
        .i_key  (bus.key_1),
        .o_rise (w_k1_rise)
    );

    game_control_fsm_key_rise #(.RST_VAL(1'b1)) u_key2_rise (
        .clk    (clk),
        .rst_n  (resetn),
        .i_key  (bus.key_2),
        .o_rise (w_k2_rise)
    );

    assign w_last_miss = (r_total_miss == MISS_W'(MISS_LIMIT - 1));
    assign w_combo_inc = (r_combo == '1) ? r_combo : r_combo + COMBO_W'(1);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic; in PLAY the priority is key_2 > miss > done > hit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_k1_rise) w_next_state = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_k2_rise) begin
`ifdef GAME_PAUSE_EN
                    w_next_state = ST_PAUSE;
`else
                    w_next_state = ST_IDLE;
`endif
                end else if (bus.miss) begin
                    if (w_last_miss)   w_next_state = ST_LOSE;
                    else if (bus.done) w_next_state = ST_WIN;
                end else if (bus.done) begin
                    w_next_state = ST_WIN;
                end
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSE: begin
                if (w_k2_rise)      w_next_state = ST_IDLE;
                else if (w_k1_rise) w_next_state = ST_PLAY;
            end
`endif
            ST_WIN, ST_LOSE: begin
                if (w_k2_rise) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Counter datapath: cleared on game start, updated only while playing.
    // A miss at MISS_LIMIT-1 increments to exactly MISS_LIMIT, and PLAY is left
    // on that same edge, so the count never exceeds the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_total_miss <= '0;
            r_combo      <= '0;
            r_max_combo  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_k1_rise) begin
                        r_total_miss <= '0;
                        r_combo      <= '0;
                        r_max_combo  <= '0;
                    end
                end
                ST_PLAY: begin
                    if (!w_k2_rise) begin
                        if (bus.miss) begin
                            r_combo      <= '0;
                            r_total_miss <= r_total_miss + MISS_W'(1);
                        end else if (!bus.done && bus.hit) begin
                            r_combo <= w_combo_inc;
                            if (w_combo_inc > r_max_combo) r_max_combo <= w_combo_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore output decode: exactly one screen select per state.
    always_comb begin
        bus.interface_sel = 1'b0;
        bus.map           = 1'b0;
        bus.paused        = 1'b0;
        bus.win           = 1'b0;
        bus.lose          = 1'b0;
        case (r_state)
            ST_IDLE: bus.interface_sel = 1'b1;
            ST_PLAY: bus.map           = 1'b1;
`ifdef GAME_PAUSE_EN
            ST_PAUSE: begin
                bus.map    = 1'b1;
                bus.paused = 1'b1;
            end
`endif
            ST_WIN:  bus.win           = 1'b1;
            ST_LOSE: bus.lose          = 1'b1;
            default: bus.interface_sel = 1'b1;
        endcase
    end

    assign bus.total_miss = r_total_miss;
    assign bus.combo      = r_combo;
    assign bus.max_combo  = r_max_combo;
endmodule

// File: tb/tb_game_control_fsm.sv
// Self-checking bench for game_control_fsm (MISS_LIMIT=7, COMBO_W=4).
// A behavioural model pushes the expected post-edge outputs to a queue as each
// cycle's stimulus is driven; a monitor pops and compares after every edge.
// Scenario tasks add inline checks against hand-derived values.
module tb_game_control_fsm;
    localparam int MISS_LIMIT = 7;
    localparam int MISS_W     = 3;
    localparam int COMBO_W    = 4;
    localparam int COMBO_MAX  = 15;

    localparam int S_IDLE  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_PAUSE = 2;
    localparam int S_WIN   = 3;
    localparam int S_LOSE  = 4;

    typedef struct {
        logic [4:0]         sel;   // {interface, map, paused, win, lose}
        logic [MISS_W-1:0]  tm;
        logic [COMBO_W-1:0] cb;
        logic [COMBO_W-1:0] mc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_pass   = 0;

    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model state
    int m_st, m_tm, m_cb, m_mc;
    bit m_k1q, m_k2q;

    game_control_fsm_if #(.MISS_W(MISS_W), .COMBO_W(COMBO_W)) bus ();

    game_control_fsm #(
        .MISS_LIMIT (MISS_LIMIT),
        .MISS_W     (MISS_W),
        .COMBO_W    (COMBO_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: one expected entry per driven cycle.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if ({bus.interface_sel, bus.map, bus.paused, bus.win, bus.lose} !== mon_e.sel ||
                bus.total_miss !== mon_e.tm || bus.combo !== mon_e.cb || bus.max_combo !== mon_e.mc)
                $display("FAIL scoreboard t=%0t got sel=%b tm=%0d cb=%0d mc=%0d want sel=%b tm=%0d cb=%0d mc=%0d",
                         $time, {bus.interface_sel, bus.map, bus.paused, bus.win, bus.lose},
                         bus.total_miss, bus.combo, bus.max_combo,
                         mon_e.sel, mon_e.tm, mon_e.cb, mon_e.mc);
            else
                n_pass++;
        end
    end

    // Drive one cycle of stimulus, advance the model, push its expectation.
    task automatic step(input bit k1, input bit k2, input bit h, input bit m, input bit d);
        bit   k1r, k2r;
        exp_t e;
        bus.key_1 = k1; bus.key_2 = k2; bus.hit = h; bus.miss = m; bus.done = d;
        k1r = k1 && !m_k1q;
        k2r = k2 && !m_k2q;
        if (!resetn) begin
            m_st = S_IDLE; m_tm = 0; m_cb = 0; m_mc = 0; m_k1q = 1; m_k2q = 1;
        end else begin
            case (m_st)
                S_IDLE: if (k1r) begin m_st = S_PLAY; m_tm = 0; m_cb = 0; m_mc = 0; end
                S_PLAY: begin
                    if (k2r) begin
`ifdef GAME_PAUSE_EN
                        m_st = S_PAUSE;
`else
                        m_st = S_IDLE;
`endif
                    end else if (m) begin
                        m_cb = 0;
                        m_tm = m_tm + 1;
                        if (m_tm == MISS_LIMIT) m_st = S_LOSE;
                        else if (d)             m_st = S_WIN;
                    end else if (d) begin
                        m_st = S_WIN;
                    end else if (h) begin
                        if (m_cb < COMBO_MAX) m_cb = m_cb + 1;
                        if (m_cb > m_mc) m_mc = m_cb;
                    end
                end
                S_PAUSE: if (k2r) m_st = S_IDLE; else if (k1r) m_st = S_PLAY;
                default: if (k2r) m_st = S_IDLE;
            endcase
            m_k1q = k1; m_k2q = k2;
        end
        e.sel = {m_st == S_IDLE, m_st == S_PLAY || m_st == S_PAUSE, m_st == S_PAUSE,
                 m_st == S_WIN, m_st == S_LOSE};
        e.tm = MISS_W'(m_tm);
        e.cb = COMBO_W'(m_cb);
        e.mc = COMBO_W'(m_mc);
        sb_q.push_back(e);
        @(posedge clk);
        #2;
        bus.hit = 0; bus.miss = 0; bus.done = 0;
        @(negedge clk);
    endtask

    task automatic start_game();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    // Return to IDLE from PLAY/PAUSE/WIN/LOSE with full key presses.
    task automatic go_idle();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        if (m_st != S_IDLE) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        resetn = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_checks++; if (bus.interface_sel !== 1'b1) $display("FAIL reset_interface got=%b want=1", bus.interface_sel); else n_pass++;
        n_checks++; if (bus.max_combo !== 4'd0) $display("FAIL reset_maxcombo got=%0d want=0", bus.max_combo); else n_pass++;
        resetn = 1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_checks++; if (bus.interface_sel !== 1'b1 || bus.map !== 1'b0)
            $display("FAIL held_key1_no_start got if=%b map=%b want if=1 map=0", bus.interface_sel, bus.map); else n_pass++;
        step(0, 0, 0, 0, 0);
        start_game();
        n_checks++; if (bus.map !== 1'b1 || bus.total_miss !== 3'd0 || bus.combo !== 4'd0)
            $display("FAIL start_play got map=%b tm=%0d cb=%0d want map=1 tm=0 cb=0", bus.map, bus.total_miss, bus.combo); else n_pass++;
        go_idle();
    endtask

    task automatic test_lose();
        start_game();
        repeat (6) step(0, 0, 0, 1, 0);
        n_checks++; if (bus.total_miss !== 3'd6 || bus.map !== 1'b1)
            $display("FAIL six_misses got tm=%0d map=%b want tm=6 map=1", bus.total_miss, bus.map); else n_pass++;
        step(0, 0, 0, 1, 0);
        n_checks++; if (bus.lose !== 1'b1 || bus.total_miss !== 3'd7)
            $display("FAIL seventh_miss got lose=%b tm=%0d want lose=1 tm=7", bus.lose, bus.total_miss); else n_pass++;
        step(0, 0, 1, 1, 1);
        n_checks++; if (bus.total_miss !== 3'd7 || bus.lose !== 1'b1)
            $display("FAIL lose_frozen got tm=%0d lose=%b want tm=7 lose=1", bus.total_miss, bus.lose); else n_pass++;
        step(0, 1, 0, 0, 0);
        n_checks++; if (bus.interface_sel !== 1'b1) $display("FAIL lose_to_idle got=%b want=1", bus.interface_sel); else n_pass++;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_win();
        start_game();
        repeat (5) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        n_checks++; if (bus.win !== 1'b1 || bus.combo !== 4'd3 || bus.max_combo !== 4'd5 || bus.total_miss !== 3'd1)
            $display("FAIL win_counts got win=%b cb=%0d mc=%0d tm=%0d want win=1 cb=3 mc=5 tm=1",
                     bus.win, bus.combo, bus.max_combo, bus.total_miss); else n_pass++;
        step(0, 0, 1, 0, 0);
        n_checks++; if (bus.combo !== 4'd3) $display("FAIL win_frozen got=%0d want=3", bus.combo); else n_pass++;
        step(0, 1, 0, 0, 0);
        n_checks++; if (bus.interface_sel !== 1'b1 || bus.combo !== 4'd3)
            $display("FAIL win_to_idle got if=%b cb=%0d want if=1 cb=3", bus.interface_sel, bus.combo); else n_pass++;
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        n_checks++; if (bus.map !== 1'b1 || bus.paused !== 1'b0)
            $display("FAIL held_key2_no_retrigger got map=%b paused=%b want map=1 paused=0", bus.map, bus.paused); else n_pass++;
        step(0, 0, 0, 0, 0);
        go_idle();
    endtask

    task automatic test_same_cycle();
        start_game();
        repeat (6) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        n_checks++; if (bus.lose !== 1'b1 || bus.total_miss !== 3'd7)
            $display("FAIL miss_done_limit got lose=%b tm=%0d want lose=1 tm=7", bus.lose, bus.total_miss); else n_pass++;
        go_idle();
        start_game();
        repeat (2) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        n_checks++; if (bus.win !== 1'b1 || bus.total_miss !== 3'd3)
            $display("FAIL miss_done_win got win=%b tm=%0d want win=1 tm=3", bus.win, bus.total_miss); else n_pass++;
        go_idle();
        start_game();
        repeat (2) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        n_checks++; if (bus.combo !== 4'd0 || bus.total_miss !== 3'd1 || bus.max_combo !== 4'd2 || bus.map !== 1'b1)
            $display("FAIL hit_miss got cb=%0d tm=%0d mc=%0d map=%b want cb=0 tm=1 mc=2 map=1",
                     bus.combo, bus.total_miss, bus.max_combo, bus.map); else n_pass++;
        step(0, 0, 1, 0, 1);
        n_checks++; if (bus.win !== 1'b1 || bus.combo !== 4'd0)
            $display("FAIL hit_done got win=%b cb=%0d want win=1 cb=0", bus.win, bus.combo); else n_pass++;
        go_idle();
    endtask

    task automatic test_saturate();
        start_game();
        repeat (20) step(0, 0, 1, 0, 0);
        n_checks++; if (bus.combo !== 4'd15 || bus.max_combo !== 4'd15)
            $display("FAIL combo_sat got cb=%0d mc=%0d want 15/15", bus.combo, bus.max_combo); else n_pass++;
        go_idle();
    endtask

    task automatic test_pause();
        start_game();
        repeat (2) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
`ifdef GAME_PAUSE_EN
        n_checks++; if (bus.paused !== 1'b1 || bus.map !== 1'b1)
            $display("FAIL pause_enter got paused=%b map=%b want 1/1", bus.paused, bus.map); else n_pass++;
        step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        n_checks++; if (bus.combo !== 4'd2 || bus.total_miss !== 3'd0 || bus.paused !== 1'b1)
            $display("FAIL pause_ignore got cb=%0d tm=%0d paused=%b want cb=2 tm=0 paused=1",
                     bus.combo, bus.total_miss, bus.paused); else n_pass++;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        n_checks++; if (bus.combo !== 4'd3 || bus.paused !== 1'b0 || bus.map !== 1'b1)
            $display("FAIL pause_resume got cb=%0d paused=%b map=%b want cb=3 paused=0 map=1",
                     bus.combo, bus.paused, bus.map); else n_pass++;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        n_checks++; if (bus.interface_sel !== 1'b1)
            $display("FAIL pause_both_keys got if=%b want=1", bus.interface_sel); else n_pass++;
        step(0, 0, 0, 0, 0);
`else
        n_checks++; if (bus.interface_sel !== 1'b1 || bus.paused !== 1'b0 || bus.combo !== 4'd2)
            $display("FAIL abort_to_idle got if=%b paused=%b cb=%0d want if=1 paused=0 cb=2",
                     bus.interface_sel, bus.paused, bus.combo); else n_pass++;
        step(0, 0, 0, 0, 0);
`endif
    endtask

    task automatic test_reset_midgame();
        start_game();
        repeat (3) step(0, 0, 1, 0, 0);
        resetn = 0;
        bus.hit = 1;
        #1;
        n_checks++; if (bus.interface_sel !== 1'b1 || bus.combo !== 4'd0 || bus.map !== 1'b0)
            $display("FAIL async_reset got if=%b cb=%0d map=%b want if=1 cb=0 map=0",
                     bus.interface_sel, bus.combo, bus.map); else n_pass++;
        step(0, 0, 1, 0, 0);
        resetn = 1;
        step(0, 0, 0, 0, 0);
        start_game();
        n_checks++; if (bus.map !== 1'b1) $display("FAIL restart_after_reset got map=%b want=1", bus.map); else n_pass++;
        go_idle();
    endtask

    initial begin
        resetn = 0;
        bus.key_1 = 0; bus.key_2 = 0; bus.hit = 0; bus.miss = 0; bus.done = 0;
        m_st = S_IDLE; m_tm = 0; m_cb = 0; m_mc = 0; m_k1q = 1; m_k2q = 1;
        @(negedge clk);
        test_reset();
        test_lose();
        test_win();
        test_same_cycle();
        test_saturate();
        test_pause();
        test_reset_midgame();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/game_control_fsm.md
# game_control_fsm

Parametrised top-level game controller for the rhythm game. It sequences title screen → play → win/lose result screens and counts misses against a configurable limit. It also tracks the current and best hit combo, and detects key presses internally on rising edges, so held keys never retrigger. It sits between the debounced push-button inputs, the note/judge datapath (hit, miss, done pulses) and the VGA/HEX display logic (screen selects, counters).

## Interface
- MISS_LIMIT, 7: misses that end the game; legal 1..255
- MISS_W, $clog2(MISS_LIMIT+1): width of total_miss
- COMBO_W, 8: width of combo counters
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- key_1  in  1  start/resume button, level, debounced, active-high
- key_2  in  1  quit/pause/acknowledge button, level, debounced, active-high
- hit  in  1  one-cycle pulse: note judged hit
- miss  in  1  one-cycle pulse: note judged missed
- done  in  1  one-cycle pulse: song finished
- interface  out  1  title screen select
- map  out  1  play-field screen select
- paused  out  1  pause overlay select (constant 0 without GAME_PAUSE_EN)
- win  out  1  win screen select
- lose  out  1  lose screen select
- total_miss  out  MISS_W  misses in current game
- combo  out  COMBO_W  current consecutive hits
- max_combo  out  COMBO_W  best combo of current game

## Operation
- States: IDLE, PLAY, PAUSE, WIN, LOSE. All outputs are registered and Moore-decoded from state and counters.
- k1_rise = key_1 & ~key_1_q; k2_rise likewise. The _q flops reset to 1, so a key held through reset gives no edge.
- IDLE: interface=1. On k1_rise → PLAY, clearing total_miss, combo and max_combo.
- PLAY: map=1. Priority is k2_rise > miss > done > hit.
  - k2_rise → PAUSE (macro on) or IDLE (macro off); same-cycle miss/hit/done are discarded.
  - miss: combo←0. If total_miss==MISS_LIMIT-1 then total_miss←MISS_LIMIT and → LOSE; else total_miss+1.
  - miss+done in the same cycle: the miss is counted first. If it reaches the limit → LOSE, else → WIN.
  - done alone → WIN.
  - hit alone: combo+1, saturating at 2^COMBO_W-1. max_combo←max(max_combo, combo+1), also saturating.
  - hit+miss in the same cycle: treated as a miss only.
- PAUSE: map=1, paused=1. hit/miss/done are ignored. k1_rise → PLAY with counters kept; k2_rise → IDLE; if both rise together, k2 wins.
- WIN: win=1; total_miss, combo and max_combo are frozen. k2_rise → IDLE.
- LOSE: lose=1; total_miss=MISS_LIMIT, combo=0, max_combo frozen. k2_rise → IDLE.
- IDLE clears nothing on entry; the counters keep their values until the next game start.
- In IDLE, WIN and LOSE, hit/miss/done are ignored.
- Exactly one of interface/map/win/lose is high in every state.

## Timing
- Reset (async assert, sync-released by the top level): state=IDLE, interface=1, map=paused=win=lose=0, total_miss=combo=max_combo=0, key_*_q=1.
- Latency: a qualifying input sampled at edge N is reflected on the outputs after edge N (one-cycle registered response). No combinational input→output path.
- A key must be low for ≥1 cycle between presses to register again.
- Reset asserted mid-game: immediate return to IDLE and counters zeroed, regardless of in-flight pulses.

## Configuration
- GAME_PAUSE_EN defined: PAUSE state exists, key_2 in PLAY pauses, paused output is live.
- Not defined: PAUSE is not compiled, key_2 in PLAY aborts to IDLE, paused tied to 0. Port list is identical in both builds.

## Structure
- game_pkg holds the state enum (game_state_t), DEFAULT_MISS_LIMIT=7, DEFAULT_COMBO_W=8; shared with the display decoder.
- Sub-module key_rise: one flop plus an AND gate with a configurable reset value; instantiated for key_1 and key_2.
- Core: one state register, counter datapath, output decode.

## Test plan
- Reset with key_1 held high, release reset → stays IDLE, interface=1. Release then press key_1 → PLAY, map=1, all counters 0.
- MISS_LIMIT=7: 6 miss pulses → total_miss=6, still PLAY. 7th miss → LOSE, lose=1, total_miss=7. key_2 press → IDLE.
- 5 hits, 1 miss, 3 hits, then done → WIN, combo=3, max_combo=5, total_miss=1. Holding key_2 continuously produces exactly one IDLE transition.
- total_miss=6 with miss and done in the same cycle → LOSE. With total_miss=2 → WIN, total_miss=3. hit+miss in the same cycle → combo=0, miss counted.
- COMBO_W=4: 20 consecutive hits → combo=max_combo=15 (saturated).
- With GAME_PAUSE_EN: key_2 during PLAY → paused=1; 3 hit and 2 miss pulses leave counters unchanged; key_1 → PLAY with values intact. Without the macro, the same key_2 press → IDLE.
